// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute controller for the PUC CPU ALU and register file
//
// Purpose:
//   Fetches 16-bit instructions {op, r1, r2, imm} from program memory, presents the
//   decoded fields to the shared ALU, and writes the ALU result back to register r1.
//   JUMPZERO and HALT are resolved here. Every other opcode is an ALU operation.
//
// Ports:
//   clock            in   system clock, rising edge
//   resetN           in   asynchronous active-low reset
//   run              in   level; high lets a new fetch start
//   programAddress   out  program memory address (= PC)
//   programData      in   instruction word, valid one cycle after programAddress
//   opCode           out  opcode to ALU
//   register1Address out  register file read port 1 (r1 field)
//   register2Address out  register file read port 2 (r2 field)
//   instructionValue out  immediate field to ALU
//   aluResult        in   combinational ALU result
//   writeEnable      out  register file write strobe (EXECUTE of ALU ops only)
//   writeAddress     out  destination register (r1 field)
//   writeData        out  aluResult passed through
//   zeroFlag         out  set when the last written result was zero
//   halted           out  high once a HALT has executed

module alu_sequencer #(
  parameter int OPCODE_WIDTH   = 4,
  parameter int REGISTER_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int PC_WIDTH       = 8,
  parameter int INSTR_WIDTH    = OPCODE_WIDTH + 2*REG_ADDR_WIDTH + REGISTER_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] OP_JUMPZERO = 4'hE,
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT     = 4'hF
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      run,
  output logic [PC_WIDTH-1:0]       programAddress,
  input  logic [INSTR_WIDTH-1:0]    programData,
  output logic [OPCODE_WIDTH-1:0]   opCode,
  output logic [REG_ADDR_WIDTH-1:0] register1Address,
  output logic [REG_ADDR_WIDTH-1:0] register2Address,
  output logic [REGISTER_WIDTH-1:0] instructionValue,
  input  logic [REGISTER_WIDTH-1:0] aluResult,
  output logic                      writeEnable,
  output logic [REG_ADDR_WIDTH-1:0] writeAddress,
  output logic [REGISTER_WIDTH-1:0] writeData,
  output logic                      zeroFlag,
  output logic                      halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [PC_WIDTH-1:0]       pc;
  logic [PC_WIDTH-1:0]       pc_inc;
  logic [INSTR_WIDTH-1:0]    ir;
  logic                      zero_flag;

  logic [OPCODE_WIDTH-1:0]   ir_op;
  logic [REG_ADDR_WIDTH-1:0] ir_r1;
  logic [REG_ADDR_WIDTH-1:0] ir_r2;
  logic [REGISTER_WIDTH-1:0] ir_imm;
  logic                      is_jz;
  logic                      is_halt;

  assign ir_op  = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_r1  = ir[REGISTER_WIDTH + 2*REG_ADDR_WIDTH - 1 -: REG_ADDR_WIDTH];
  assign ir_r2  = ir[REGISTER_WIDTH + REG_ADDR_WIDTH - 1 -: REG_ADDR_WIDTH];
  assign ir_imm = ir[REGISTER_WIDTH-1:0];

  assign is_jz   = (ir_op == OP_JUMPZERO);
  assign is_halt = (ir_op == OP_HALT);

  // Natural width truncation gives the modulo-2^PC_WIDTH wrap.
  assign pc_inc = pc + PC_WIDTH'(1);

  // The ALU-facing fields come straight from the instruction register; it only
  // changes at the end of DECODE, so they are stable through EXECUTE and hold afterwards.
  assign programAddress   = pc;
  assign opCode           = ir_op;
  assign register1Address = ir_r1;
  assign register2Address = ir_r2;
  assign instructionValue = ir_imm;
  assign writeAddress     = ir_r1;
  assign writeData        = aluResult;
  assign zeroFlag         = zero_flag;
  assign halted           = (state == S_HALTED);

  // Decoded from the state register, so an asynchronous reset drops the strobe at once.
  assign writeEnable = (state == S_EXECUTE) && !is_jz && !is_halt;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (run) next_state = S_DECODE;
      S_DECODE:  next_state = S_EXECUTE;
      S_EXECUTE: next_state = is_halt ? S_HALTED : S_FETCH;
      S_HALTED:  next_state = S_HALTED;
      default:   next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc        <= '0;
      ir        <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        S_DECODE: ir <= programData;
        S_EXECUTE: begin
          if (is_jz) begin
            pc <= zero_flag ? ir_imm[PC_WIDTH-1:0] : pc_inc;
          end else if (!is_halt) begin
            zero_flag <= (aluResult == '0);
            pc        <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with instruction-level model

module tb_alu_sequencer;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  programAddress;
  logic [15:0] programData = '0;
  logic [3:0]  opCode;
  logic [1:0]  register1Address;
  logic [1:0]  register2Address;
  logic [7:0]  instructionValue;
  logic [7:0]  aluResult;
  logic        writeEnable;
  logic [1:0]  writeAddress;
  logic [7:0]  writeData;
  logic        zeroFlag;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [7:0]  rf [4] = '{default: 8'h00};

  alu_sequencer dut (
    .clock(clock), .resetN(resetN), .run(run),
    .programAddress(programAddress), .programData(programData),
    .opCode(opCode), .register1Address(register1Address),
    .register2Address(register2Address), .instructionValue(instructionValue),
    .aluResult(aluResult), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .zeroFlag(zeroFlag), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] imm);
    case (op)
      OP_LOAD: return imm;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_INC:  return a + 8'd1;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [15:0] ins(logic [3:0] op, logic [1:0] r1, logic [1:0] r2, logic [7:0] imm);
    return {op, r1, r2, imm};
  endfunction

  // External environment: registered program ROM, combinational ALU, register file.
  always @(posedge clock) programData <= mem[programAddress];
  always_comb aluResult = alu_fn(opCode, rf[register1Address], rf[register2Address], instructionValue);
  always @(posedge clock) if (writeEnable) rf[writeAddress] <= writeData;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: an accepted fetch commits the whole instruction two
  // cycles later (3-cycle latency); architectural effects become visible after that.
  logic [7:0]  m_pc = '0;
  logic        m_zf = 1'b0;
  logic        m_halt = 1'b0;
  int          m_pending = 0;
  logic [15:0] m_ins = '0;
  logic [7:0]  m_regs [4] = '{default: 8'h00};

  always @(negedge clock) begin
    logic [3:0] op;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [7:0] imm;
    logic [7:0] res;
    logic       exp_we;
    if (!resetN) begin
      m_pc = '0; m_zf = 1'b0; m_halt = 1'b0; m_pending = 0;
      chk("rst_we", 32'(writeEnable), 32'd0);
      chk("rst_pc", 32'(programAddress), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_zf", 32'(zeroFlag), 32'd0);
    end else begin
      chk("m_pc", 32'(programAddress), 32'(m_pc));
      chk("m_halted", 32'(halted), 32'(m_halt));
      chk("m_zf", 32'(zeroFlag), 32'(m_zf));
      exp_we = 1'b0;
      if (m_pending == 2) begin
        {op, r1, r2, imm} = m_ins;
        chk("m_opcode", 32'(opCode), 32'(op));
        chk("m_r1addr", 32'(register1Address), 32'(r1));
        chk("m_r2addr", 32'(register2Address), 32'(r2));
        chk("m_imm", 32'(instructionValue), 32'(imm));
        if (op == OP_HALT) begin
          m_halt = 1'b1;
        end else if (op == OP_JZ) begin
          m_pc = m_zf ? imm : m_pc + 8'd1;
        end else begin
          exp_we = 1'b1;
          res = alu_fn(op, m_regs[r1], m_regs[r2], imm);
          chk("m_waddr", 32'(writeAddress), 32'(r1));
          chk("m_wdata", 32'(writeData), 32'(res));
          m_regs[r1] = res;
          m_zf = (res == 8'd0);
          m_pc = m_pc + 8'd1;
        end
        m_pending = 0;
      end else if (m_pending == 1) begin
        m_pending = 2;
      end else if (!m_halt && run) begin
        m_ins = mem[m_pc];
        m_pending = 1;
      end
      chk("m_we", 32'(writeEnable), 32'(exp_we));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reset is released 2 time units after an edge, leaving a full FETCH cycle after it.
  task automatic do_reset(logic run_val);
    resetN = 1'b0;
    run = run_val;
    @(posedge clock);
    #2;
    resetN = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] saved;
    clear_mem();
    #1;
    chk("init_we", 32'(writeEnable), 32'd0);
    chk("init_opcode", 32'(opCode), 32'd0);
    chk("init_imm", 32'(instructionValue), 32'd0);

    // 1: single LOAD, write in cycle 3
    mem[0] = ins(OP_LOAD, 2'd1, 2'd0, 8'h2A);
    do_reset(1'b1);
    step(1);
    chk("t1_we_c2", 32'(writeEnable), 32'd0);
    step(1);
    chk("t1_we_c3", 32'(writeEnable), 32'd1);
    chk("t1_waddr", 32'(writeAddress), 32'd1);
    chk("t1_wdata", 32'(writeData), 32'h2A);
    step(1);
    chk("t1_pc", 32'(programAddress), 32'd1);
    chk("t1_zf", 32'(zeroFlag), 32'd0);
    step(4);

    // 2: run held low, then first write three cycles after run rises
    clear_mem();
    mem[0] = ins(OP_LOAD, 2'd2, 2'd0, 8'h11);
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t2_pc_idle", 32'(programAddress), 32'd0);
      chk("t2_we_idle", 32'(writeEnable), 32'd0);
    end
    run = 1'b1;
    step(1);
    chk("t2_we_c2", 32'(writeEnable), 32'd0);
    step(1);
    chk("t2_we_c3", 32'(writeEnable), 32'd1);
    step(4);

    // 3: LOAD 0 then JUMPZERO taken
    clear_mem();
    mem[0] = ins(OP_LOAD, 2'd0, 2'd0, 8'h00);
    mem[1] = ins(OP_JZ, 2'd0, 2'd0, 8'h10);
    do_reset(1'b1);
    step(3);
    chk("t3_zf", 32'(zeroFlag), 32'd1);
    step(2);
    chk("t3_jz_op", 32'(opCode), 32'(OP_JZ));
    chk("t3_jz_we", 32'(writeEnable), 32'd0);
    step(1);
    chk("t3_pc", 32'(programAddress), 32'h10);
    chk("t3_zf_kept", 32'(zeroFlag), 32'd1);
    step(4);

    // 4: LOAD 5 then JUMPZERO not taken
    clear_mem();
    mem[0] = ins(OP_LOAD, 2'd0, 2'd0, 8'h05);
    mem[1] = ins(OP_JZ, 2'd0, 2'd0, 8'h10);
    do_reset(1'b1);
    step(3);
    chk("t4_zf", 32'(zeroFlag), 32'd0);
    step(3);
    chk("t4_pc", 32'(programAddress), 32'd2);
    step(4);

    // 5: ADD at 0xFF wraps PC, HALT at 0x00 freezes everything
    clear_mem();
    mem[0]    = ins(OP_LOAD, 2'd0, 2'd0, 8'h00);
    mem[1]    = ins(OP_JZ, 2'd0, 2'd0, 8'hFF);
    mem[8'hFF] = ins(OP_ADD, 2'd1, 2'd2, 8'h00);
    do_reset(1'b1);
    step(6);
    chk("t5_pc_ff", 32'(programAddress), 32'hFF);
    mem[0] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    step(3);
    chk("t5_pc_wrap", 32'(programAddress), 32'h00);
    step(3);
    chk("t5_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t5_pc_hold", 32'(programAddress), 32'h00);
      chk("t5_we_hold", 32'(writeEnable), 32'd0);
      chk("t5_halt_hold", 32'(halted), 32'd1);
    end

    // 6: asynchronous reset during EXECUTE of an INC
    clear_mem();
    mem[0] = ins(OP_LOAD, 2'd0, 2'd0, 8'h00);
    mem[1] = ins(OP_INC, 2'd3, 2'd0, 8'h00);
    do_reset(1'b1);
    step(5);
    chk("t6_inc_op", 32'(opCode), 32'(OP_INC));
    chk("t6_inc_we", 32'(writeEnable), 32'd1);
    chk("t6_zf_pre", 32'(zeroFlag), 32'd1);
    saved = rf[3];
    #1;
    resetN = 1'b0;
    #1;
    chk("t6_we", 32'(writeEnable), 32'd0);
    chk("t6_pc", 32'(programAddress), 32'd0);
    chk("t6_opcode", 32'(opCode), 32'd0);
    chk("t6_r1", 32'(register1Address), 32'd0);
    chk("t6_imm", 32'(instructionValue), 32'd0);
    chk("t6_zf", 32'(zeroFlag), 32'd0);
    chk("t6_halted", 32'(halted), 32'd0);
    @(posedge clock);
    #2;
    chk("t6_no_write", 32'(rf[3]), 32'(saved));
    resetN = 1'b1;
    step(8);

    // Randomized programs with random run gaps
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) begin
        int sel;
        logic [3:0] op;
        logic [7:0] imm;
        sel = $urandom_range(0, 39);
        imm = 8'($urandom_range(0, 255));
        if (sel == 0) op = OP_HALT;
        else if (sel < 8) op = OP_JZ;
        else op = 4'($urandom_range(0, 5));
        if (op == OP_LOAD && $urandom_range(0, 3) == 0) imm = 8'h00;
        mem[i] = ins(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), imm);
      end
      do_reset(1'b1);
      for (int c = 0; c < 600; c++) begin
        run = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
